// File: rtl/tap_mac_correlator_pkg.sv
// Shared types, default widths and helpers for the tap MAC correlator.
// Optional result clipping is selected with the TAP_MAC_SAT_EN macro (see tap_mac_correlator.sv).
package tap_mac_correlator_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_DONE} mac_state_t;

    localparam int NTAPS_DEF  = 10;
    localparam int DATA_W_DEF = 5;
    localparam int COEF_W_DEF = 5;
    localparam int OUT_W_DEF  = 10;

    // Accumulator wide enough that summing ntaps full-scale products cannot overflow.
    function automatic int acc_width(input int ntaps, input int data_w, input int coef_w);
        return data_w + coef_w + $clog2(ntaps);
    endfunction

    // Symmetric clip to +/-(2^(width-1)-1); the most negative code is deliberately excluded.
    function automatic logic signed [31:0] sat_sym(input logic signed [31:0] value,
                                                   input int width);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (width - 1)) - 32'sd1;
        if (value > lim) begin
            return lim;
        end else if (value < -lim) begin
            return -lim;
        end
        return value;
    endfunction

endpackage

// File: rtl/tap_mac_correlator_if.sv
// Request/result bundle between the correlator and its client (delay line side / decision logic).
interface tap_mac_correlator_if
    import tap_mac_correlator_pkg::*;
#(
    parameter int p_ntaps  = NTAPS_DEF,
    parameter int p_data_w = DATA_W_DEF,
    parameter int p_coef_w = COEF_W_DEF,
    parameter int p_acc_w  = acc_width(p_ntaps, p_data_w, p_coef_w)
);

    logic                              start;
    logic [p_ntaps*p_data_w-1:0]       taps_in;
    logic [p_ntaps*p_coef_w-1:0]       coef_in;
    logic                              busy;
    logic signed [p_acc_w-1:0]         result;
    logic                              result_valid;
    logic                              overrun;

    modport master (
        output start, taps_in, coef_in,
        input  busy, result, result_valid, overrun
    );

    modport slave (
        input  start, taps_in, coef_in,
        output busy, result, result_valid, overrun
    );

endinterface

// File: rtl/tap_mac_correlator_mac_unit.sv
// Registered signed multiply-accumulate with synchronous clear and enable.
module mac_unit #(
    parameter int p_a_w   = 5,
    parameter int p_b_w   = 5,
    parameter int p_acc_w = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      en,
    input  logic signed [p_a_w-1:0]   a,
    input  logic signed [p_b_w-1:0]   b,
    output logic signed [p_acc_w-1:0] acc
);

    localparam int p_prod_w = p_a_w + p_b_w;

    logic signed [p_prod_w-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + p_acc_w'(prod);
        end
    end

endmodule

// File: rtl/tap_mac_correlator.sv
// Serial tap-by-coefficient correlator: snapshot on start, one MAC per clock, pulsed result.
// Define TAP_MAC_SAT_EN to clip the result symmetrically to p_out_w bits.
//
// state   | meaning
// ST_IDLE | waiting for start; accepted start captures taps/coefs and clears acc
// ST_ACC  | one tap*coef accumulated per clock, idx 0..p_ntaps-1
// ST_DONE | acc copied to result, result_valid pulsed, busy dropped
module tap_mac_correlator
    import tap_mac_correlator_pkg::*;
#(
    parameter int p_ntaps  = NTAPS_DEF,
    parameter int p_data_w = DATA_W_DEF,
    parameter int p_coef_w = COEF_W_DEF,
    parameter int p_out_w  = OUT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    tap_mac_correlator_if.slave  bus
);

    localparam int p_acc_w = acc_width(p_ntaps, p_data_w, p_coef_w);
    localparam int p_idx_w = $clog2(p_ntaps);
    localparam logic [p_idx_w-1:0] p_idx_last = p_idx_w'(p_ntaps - 1);

    generate
        if (p_ntaps < 2 || p_out_w > p_acc_w || p_out_w < 2) begin : g_bad_params
            $error("tap_mac_correlator: invalid parameter combination");
        end
    endgenerate

    mac_state_t state, state_next;

    logic [p_idx_w-1:0]          idx;
    logic signed [p_data_w-1:0]  tap_snap  [p_ntaps];
    logic signed [p_coef_w-1:0]  coef_snap [p_ntaps];

    logic capture;
    logic acc_en;
    logic load_result;
    logic drop_start;

    logic signed [p_acc_w-1:0] acc;
    logic signed [p_acc_w-1:0] result_next;

    logic                      busy_q;
    logic signed [p_acc_w-1:0] result_q;
    logic                      result_valid_q;
    logic                      overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        acc_en      = 1'b0;
        load_result = 1'b0;
        drop_start  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    capture    = 1'b1;
                    state_next = ST_ACC;
                end
            end
            ST_ACC: begin
                acc_en     = 1'b1;
                drop_start = bus.start;
                if (idx == p_idx_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                load_result = 1'b1;
                drop_start  = bus.start;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Snapshots isolate the running sum from the live delay line.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < p_ntaps; k++) begin
                tap_snap[k]  <= bus.taps_in[k*p_data_w +: p_data_w];
                coef_snap[k] <= bus.coef_in[k*p_coef_w +: p_coef_w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if (acc_en && idx != p_idx_last) begin
            idx <= idx + p_idx_w'(1);
        end
    end

    mac_unit #(
        .p_a_w   (p_data_w),
        .p_b_w   (p_coef_w),
        .p_acc_w (p_acc_w)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clear (capture),
        .en    (acc_en),
        .a     (tap_snap[idx]),
        .b     (coef_snap[idx]),
        .acc   (acc)
    );

`ifdef TAP_MAC_SAT_EN
    assign result_next = p_acc_w'(sat_sym(32'(acc), p_out_w));
`else
    assign result_next = acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            result_valid_q <= load_result;
            overrun_q      <= drop_start;
            if (capture) begin
                busy_q <= 1'b1;
            end else if (load_result) begin
                busy_q <= 1'b0;
            end
            if (load_result) begin
                result_q <= result_next;
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_tap_mac_correlator.sv
// Self-checking bench for tap_mac_correlator: directed corner vectors plus random vectors
// compared against a dot-product reference model.
module tb_tap_mac_correlator;
    import tap_mac_correlator_pkg::*;

    localparam int NT = 10;
    localparam int DW = 5;
    localparam int CW = 5;
    localparam int OW = 10;
    localparam int AW = DW + CW + $clog2(NT);
    localparam int TW = NT * DW;
    localparam int KW = NT * CW;

    localparam int MODE_PLAIN    = 0;
    localparam int MODE_OVERRUN  = 1;
    localparam int MODE_SCRAMBLE = 2;
    localparam int MODE_RESET    = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    tap_mac_correlator_if #(.p_ntaps(NT), .p_data_w(DW), .p_coef_w(CW)) bus ();

    tap_mac_correlator #(
        .p_ntaps  (NT),
        .p_data_w (DW),
        .p_coef_w (CW),
        .p_out_w  (OW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int t [NT];
    int c [NT];
    longint last_result = 0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model();
        longint sum;
        longint lim;
        sum = 0;
        for (int k = 0; k < NT; k++) begin
            sum += longint'(t[k]) * longint'(c[k]);
        end
`ifdef TAP_MAC_SAT_EN
        lim = (longint'(1) << (OW - 1)) - 1;
        if (sum > lim) sum = lim;
        if (sum < -lim) sum = -lim;
`else
        lim = 0;
        sum += lim;
`endif
        return sum;
    endfunction

    task automatic drive_vectors();
        logic [DW-1:0] tv;
        logic [CW-1:0] cv;
        for (int k = 0; k < NT; k++) begin
            tv = DW'(t[k]);
            cv = CW'(c[k]);
            bus.taps_in[k*DW +: DW] = tv;
            bus.coef_in[k*CW +: CW] = cv;
        end
    endtask

    task automatic randomize_vectors();
        for (int k = 0; k < NT; k++) begin
            t[k] = int'($urandom_range(0, 31)) - 16;
            c[k] = int'($urandom_range(0, 31)) - 16;
        end
    endtask

    task automatic run_one(input string tag, input int mode);
        longint exp;
        int edges;
        exp = model();
        @(negedge clk);
        drive_vectors();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 1;
        check({tag, "_busy_hi"}, longint'(bus.busy), 1);
        while (!bus.result_valid && edges < 40) begin
            if (mode == MODE_SCRAMBLE) begin
                bus.taps_in = TW'({$urandom, $urandom});
                bus.coef_in = KW'({$urandom, $urandom});
            end
            if (mode == MODE_OVERRUN && edges == 5) bus.start = 1'b1;
            if (mode == MODE_RESET && edges == 6) reset = 1'b1;
            @(negedge clk);
            edges++;
            if (mode == MODE_OVERRUN && edges == 6) begin
                bus.start = 1'b0;
                check({tag, "_ovr_pulse"}, longint'(bus.overrun), 1);
            end
            if (mode == MODE_OVERRUN && edges == 7)
                check({tag, "_ovr_clear"}, longint'(bus.overrun), 0);
            if (mode == MODE_RESET && edges == 7) begin
                reset = 1'b0;
                check({tag, "_rst_busy"}, longint'(bus.busy), 0);
                check({tag, "_rst_result"}, longint'(bus.result), 0);
                last_result = 0;
                for (int i = 0; i < 15; i++) begin
                    @(negedge clk);
                    check({tag, "_rst_novalid"}, longint'(bus.result_valid), 0);
                end
                return;
            end
        end
        check({tag, "_latency"}, longint'(edges), longint'(NT + 2));
        check({tag, "_result"}, longint'(bus.result), exp);
        check({tag, "_busy_lo"}, longint'(bus.busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_single_valid"}, longint'(bus.result_valid), 0);
            check({tag, "_held"}, longint'(bus.result), exp);
        end
        last_result = exp;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.taps_in = '0;
        bus.coef_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_result", longint'(bus.result), 0);
        check("rst_valid", longint'(bus.result_valid), 0);
        check("rst_overrun", longint'(bus.overrun), 0);

        for (int k = 0; k < NT; k++) begin t[k] = 1; c[k] = 1; end
        run_one("ones", MODE_PLAIN);
        check("ones_abs", last_result, 10);

        for (int k = 0; k < NT; k++) begin t[k] = -16; c[k] = -16; end
        run_one("negmax", MODE_PLAIN);

        for (int k = 0; k < NT; k++) begin t[k] = k; c[k] = (k % 2 == 0) ? 1 : -1; end
        run_one("ramp_alt", MODE_PLAIN);
        check("ramp_alt_abs", last_result, -5);

        for (int k = 0; k < NT; k++) begin t[k] = 15; c[k] = -16; end
        run_one("posneg", MODE_PLAIN);

        randomize_vectors();
        run_one("overrun", MODE_OVERRUN);

        randomize_vectors();
        run_one("scramble", MODE_SCRAMBLE);

        randomize_vectors();
        run_one("midreset", MODE_RESET);
        randomize_vectors();
        run_one("post_reset", MODE_PLAIN);

        for (int n = 0; n < 8; n++) begin
            randomize_vectors();
            run_one("random", MODE_PLAIN);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
